// File: rtl/digit_scan_pkg.sv
// Shared types and slot-selection helpers for the digit scan controller.
package digit_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } slot_sel_t;

  // Next non-skipped slot after cur, ascending with wrap 3->0.
  // cur itself is the last candidate, so a single enabled slot re-selects itself.
  // Calling with cur=3 yields the lowest non-skipped slot.
  function automatic slot_sel_t next_slot(input logic [1:0] cur, input logic [3:0] skip);
    slot_sel_t  r;
    logic [1:0] c;
    r.valid = 1'b0;
    r.idx   = cur;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = 4; k >= 1; k--) begin
      c = cur + k[1:0];
      if (!skip[c]) begin
        r.valid = 1'b1;
        r.idx   = c;
      end
    end
    return r;
  endfunction

  // Highest-indexed non-skipped slot; frame_done is raised at the end of it.
  function automatic logic [1:0] last_slot(input logic [3:0] skip);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!skip[i]) r = i[1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Cycle counter shared by the ACTIVE and GAP phases. Counts 0..target and
// parks there (no wrap); load restarts it at 0. target is the duration minus
// one, so a full 2^CNT_W-cycle duration still fits in CNT_W bits.
module scan_slot_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] target,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  assign cnt  = cnt_q;
  assign done = (cnt_q == target);

  // Advance the count until the target is reached; load restarts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (!done) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/digit_scan_controller.sv
// Scan engine driving a 2-to-4 decoder: steps through non-skipped slots,
// holding en high SLOT_CYCLES per slot with GAP_CYCLES of blanking between.
// Every output is registered and computed from the next state, so the
// address only moves on the edge where en rises (or into IDLE).
module digit_scan_controller
  import digit_scan_pkg::*;
#(
  parameter int SLOT_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] skip,
  output logic       A,
  output logic       B,
  output logic       en,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [CNT_W-1:0] SLOT_M1 = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_M1  = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
  localparam bit               HAS_GAP = (GAP_CYCLES != 0);

  scan_state_t      state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [1:0]       last_q, last_d;
  logic             a_q, b_q, en_q, busy_q, fd_q;
  logic             a_d, b_d, en_d, busy_d, fd_d;
  logic             sel;
  logic             load;
  logic [CNT_W-1:0] tmr_cnt, cnt_next, tmr_target;
  logic             tmr_done;
  slot_sel_t        first_sel, next_sel;

  assign first_sel  = next_slot(2'd3, skip);
  assign next_sel   = next_slot(slot_q, skip);
  assign tmr_target = (state_q == GAP) ? GAP_M1 : SLOT_M1;

  scan_slot_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .target (tmr_target),
    .cnt    (tmr_cnt),
    .done   (tmr_done)
  );

  // FSM next state and slot selection; skip is only looked at when a slot is chosen.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    last_d  = last_q;
    sel     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop && first_sel.valid) begin
          state_d = ACTIVE;
          slot_d  = first_sel.idx;
          last_d  = last_slot(skip);
          sel     = 1'b1;
        end
      end
      ACTIVE, GAP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tmr_done) begin
          if (state_q == ACTIVE && HAS_GAP) begin
            state_d = GAP;
          end else if (next_sel.valid) begin
            state_d = ACTIVE;
            slot_d  = next_sel.idx;
            last_d  = last_slot(skip);
            sel     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Timer restarts on any state change or new slot, and stays cleared in IDLE.
  assign load     = sel || (state_d != state_q) || (state_q == IDLE);
  assign cnt_next = load ? '0 : (tmr_cnt + CNT_W'(1));

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    busy_d = (state_d != IDLE);
    en_d   = (state_d == ACTIVE);
    a_d    = busy_d & slot_d[1];
    b_d    = busy_d & slot_d[0];
    fd_d   = en_d && (slot_d == last_d) && (cnt_next == SLOT_M1);
  end

  // State and output registers; reset clears everything without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= 2'd0;
      last_q  <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
    end
  end

  assign A          = a_q;
  assign B          = b_q;
  assign en         = en_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_digit_scan_controller.sv
// Bench for digit_scan_controller: two instances (defaults, and 1-cycle slots
// with no gap) share stimulus; a slot/phase model is compared every cycle,
// plus literal spot checks at hand-derived cycles.
module tb_digit_scan_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] skip;
  logic       a0, b0, en0, busy0, fd0;
  logic       a1, b1, en1, busy1, fd1;

  int vectors;
  int miscompares;

  digit_scan_controller #(.SLOT_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .skip(skip),
    .A(a0), .B(b0), .en(en0), .busy(busy0), .frame_done(fd0)
  );

  digit_scan_controller #(.SLOT_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .skip(skip),
    .A(a1), .B(b1), .en(en1), .busy(busy1), .frame_done(fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model: slot index + phase within the slot period ----------
  int m_s[2];
  int m_g[2];
  bit m_busy[2];
  int m_slot[2];
  int m_phase[2];
  int m_last[2];

  function automatic int lowest_en(input logic [3:0] sk);
    int r;
    r = -1;
    for (int i = 3; i >= 0; i--) if (!sk[i]) r = i;
    return r;
  endfunction

  function automatic int highest_en(input logic [3:0] sk);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (!sk[i]) r = i;
    return r;
  endfunction

  task automatic model_step();
    int ns;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] = 1'b0;
      end else if (!m_busy[i]) begin
        if (start && !stop && lowest_en(skip) >= 0) begin
          m_busy[i]  = 1'b1;
          m_slot[i]  = lowest_en(skip);
          m_last[i]  = highest_en(skip);
          m_phase[i] = 0;
        end
      end else if (stop) begin
        m_busy[i] = 1'b0;
      end else begin
        m_phase[i]++;
        if (m_phase[i] == m_s[i] + m_g[i]) begin
          ns = -1;
          for (int k = 1; k <= 4; k++)
            if (ns < 0 && !skip[(m_slot[i] + k) % 4]) ns = (m_slot[i] + k) % 4;
          if (ns < 0) begin
            m_busy[i] = 1'b0;
          end else begin
            m_slot[i]  = ns;
            m_last[i]  = highest_en(skip);
            m_phase[i] = 0;
          end
        end
      end
    end
  endtask

  // Expected {A,B,en,busy,frame_done} for instance i.
  function automatic logic [4:0] model_out(input int i);
    logic e;
    if (!m_busy[i]) return 5'b0;
    e = (m_phase[i] < m_s[i]);
    return {m_slot[i][1], m_slot[i][0], e, 1'b1,
            e && (m_phase[i] == m_s[i] - 1) && (m_slot[i] == m_last[i])};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_dut0", {a0, b0, en0, busy0, fd0}, model_out(0));
    check("model_dut1", {a1, b1, en1, busy1, fd1}, model_out(1));
  endtask

  int fdc0, fdc1, first_fd0, bad;

  initial begin
    vectors = 0; miscompares = 0;
    m_s = '{4, 1}; m_g = '{1, 0};
    m_busy = '{0, 0}; m_slot = '{0, 0}; m_phase = '{0, 0}; m_last = '{0, 0};
    rst = 1'b1; start = 1'b0; stop = 1'b0; skip = 4'b0000;

    $display("step: reset");
    tick(); tick();
    check("reset_dut0", {a0, b0, en0, busy0, fd0}, 5'b00000);
    rst = 1'b0;
    tick();

    $display("step: full scan defaults skip=0000");
    start = 1'b1; tick(); start = 1'b0;
    check("start_latency", {a0, b0, en0, busy0}, 4'b0011);
    fdc0 = fd0; fdc1 = fd1; first_fd0 = 0;
    for (int c = 2; c <= 40; c++) begin
      tick();
      if (fd0) begin
        fdc0++;
        if (first_fd0 == 0) first_fd0 = c;
      end
      if (fd1) fdc1++;
      if (c == 5) check("gap_slot0", {a0, b0, en0}, 3'b000);
      if (c == 6) check("slot1_rise", {a0, b0, en0}, 3'b011);
      if (c == 16) check("slot3_rise", {a0, b0, en0}, 3'b111);
    end
    check("fd_count_dut0", 5'(fdc0), 5'd2);
    check("fd_first_dut0", 5'(first_fd0), 5'd19);
    check("fd_count_dut1", 5'(fdc1), 5'd10);

    $display("step: async reset mid slot 1");
    for (int c = 41; c <= 47; c++) tick();
    check("pre_reset", {a0, b0, en0, busy0}, 4'b0111);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dut0", {a0, b0, en0, busy0, fd0}, 5'b00000);
    check("async_rst_dut1", {a1, b1, en1, busy1, fd1}, 5'b00000);
    tick(); rst = 1'b0;
    tick(); tick();
    check("no_resume", {1'b0, busy0, busy1}, 3'b000);

    $display("step: skip=0101");
    skip = 4'b0101; start = 1'b1; tick(); start = 1'b0;
    check("skip_first", {a0, b0, en0}, 3'b011);
    fdc0 = fd0; bad = 0;
    for (int c = 2; c <= 20; c++) begin
      tick();
      if (fd0) fdc0++;
      if (en0 && !b0) bad++;
    end
    check("skip_fd_count", 5'(fdc0), 5'd2);
    check("skip_no_even", 5'(bad), 5'd0);
    stop = 1'b1; tick(); stop = 1'b0; skip = 4'b0000;

    $display("step: stop in cycle 2 of slot 1");
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 2; c <= 7; c++) tick();
    check("slot1_cyc2", {a0, b0, en0}, 3'b011);
    stop = 1'b1; tick();
    check("stop_dut0", {en0, busy0}, 2'b00);
    stop = 1'b0;

    $display("step: start with stop in idle, then restart");
    start = 1'b1; stop = 1'b1; tick();
    check("start_stop_idle", {1'b0, busy0, busy1}, 3'b000);
    stop = 1'b0; tick();
    check("restart_lowest", {a0, b0, en0, busy0}, 4'b0011);
    tick(); tick(); tick();
    start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;

    $display("step: all-skip");
    skip = 4'b1111; start = 1'b1; tick();
    check("allskip_start", {1'b0, busy0, busy1}, 3'b000);
    start = 1'b0; skip = 4'b0000; tick();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    skip = 4'b1111;
    tick();
    check("allskip_c4", {4'b0, busy0}, 5'b00001);
    tick();
    check("allskip_gap", {en0, busy0}, 2'b01);
    tick();
    check("allskip_idle", {a0, b0, en0, busy0, fd0}, 5'b00000);
    skip = 4'b0000;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
